hilo_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair. It executes MULT, MULTU, MADD, MSUB, DIV, DIVU, MTHI and MTLO with a Start/Busy/Done handshake, using one iteration per operand bit. It sits beside the single-cycle datapath ALU in the EX stage. The pipeline stalls on Busy and reads Hi/Lo directly for MFHI/MFLO.

---
 rtl/hilo_muldiv_unit.sv | 86 ++++++++
 tb/tb_hilo_muldiv_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide unit owning the HI/LO register pair
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic [WIDTH-1:0] b_q, a_mag, b_mag, diff, quo, rem;
  logic [2*WIDTH-1:0] prod, mul_nx, div_nx, step_nx, sprod, result;
  logic [WIDTH:0] sum, rem_sh;
  logic sa_q, sb_q, dz_q, accept, last, sgn, ge;
  assign sgn = Op inside {3'd0, 3'd2, 3'd3, 3'd4};
  assign a_mag = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag = (sgn && B[WIDTH-1]) ? -B : B;
  assign accept = Start && state != RUN;
  assign last = state == RUN && cnt == CW'(WIDTH - 1);
  // Multiply and divide share prod: {partial/remainder, multiplier/dividend}
  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b_q} : '0);
    mul_nx = {sum, prod[WIDTH-1:1]};
    rem_sh = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    ge = rem_sh >= {1'b0, b_q};
    diff = rem_sh[WIDTH-1:0] - b_q;
    div_nx = ge ? {diff, prod[WIDTH-2:0], 1'b1} : {rem_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    step_nx = op_q[2] ? div_nx : mul_nx;
    quo = step_nx[WIDTH-1:0];
    rem = step_nx[2*WIDTH-1:WIDTH];
    sprod = (sa_q ^ sb_q) ? -step_nx : step_nx;
    result = op_q[2] ? {sa_q ? -rem : rem, (sa_q ^ sb_q) ? -quo : quo}
           : op_q == 3'd2 ? {Hi, Lo} + sprod
           : op_q == 3'd3 ? {Hi, Lo} - sprod
           : sprod;
  end
  always_ff @(posedge Clk)
    state <= Reset ? IDLE : state_nx;
  always_comb
    state_nx = state == RUN ? (last ? FIN : RUN)
             : accept ? (Op[2:1] == 2'b11 ? FIN : RUN)
             : IDLE;
  always_comb begin
    Busy = state == RUN;
    Done = state == FIN;
    DivByZero = state == FIN && dz_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Hi <= '0;
      Lo <= '0;
      cnt <= '0;
      op_q <= '0;
      b_q <= '0;
      prod <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      dz_q <= 1'b0;
    end else if (accept) begin
      op_q <= Op;
      b_q <= b_mag;
      prod <= {{WIDTH{1'b0}}, a_mag};
      sa_q <= sgn && A[WIDTH-1];
      sb_q <= sgn && B[WIDTH-1];
      dz_q <= Op[2:1] == 2'b10 && B == '0;
      cnt <= '0;
      if (Op == 3'd6) Hi <= A;
      if (Op == 3'd7) Lo <= A;
    end else if (state == RUN) begin
      prod <= step_nx;
      cnt <= cnt + 1'b1;
      if (last && !dz_q) {Hi, Lo} <= result;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard bench with an arithmetic reference model of HI/LO
module tb_hilo_muldiv_unit;
  logic Clk = 0, Reset = 1, Start = 0;
  logic [2:0] Op = 0;
  logic [31:0] A = 0, B = 0, Hi, Lo;
  logic Busy, Done, DivByZero;
  typedef struct {int cyc; logic [31:0] hi, lo; logic dz;} exp_t;
  exp_t q[$];
  int cyc = 0, tests = 0, fails = 0, pend_done = 0, run_from = 0, run_to = 0;
  logic [31:0] model_hi = 0, model_lo = 0, arch_hi = 0, arch_lo = 0;
  logic started = 0;
  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  // Monitor: pops the scoreboard on Done and checks Hi/Lo stay architectural otherwise
  always @(negedge Clk) if (started) begin
    exp_t e;
    chk("busy", 64'(Busy), 64'(cyc >= run_from && cyc < run_to));
    if (Done) begin
      if (q.size() == 0) chk("unexpected_done", 64'(Done), 64'd0);
      else begin
        e = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("hi", 64'(Hi), 64'(e.hi));
        chk("lo", 64'(Lo), 64'(e.lo));
        chk("div_by_zero", 64'(DivByZero), 64'(e.dz));
        arch_hi = e.hi;
        arch_lo = e.lo;
      end
    end else begin
      chk("hold_hi", 64'(Hi), 64'(arch_hi));
      chk("hold_lo", 64'(Lo), 64'(arch_lo));
      chk("dz_idle", 64'(DivByZero), 64'd0);
      if (q.size() != 0 && cyc > q[0].cyc) begin
        chk("missing_done", 64'(cyc), 64'(q[0].cyc));
        void'(q.pop_front());
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output logic dz);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    dz = 0;
    p = {model_hi, model_lo};
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: p = p + sa * sb;
      3'd3: p = p - sa * sb;
      3'd4: if (b == 0) dz = 1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, a};
            else p = {32'(ia % ib), 32'(ia / ib)};
      3'd5: if (b == 0) dz = 1; else p = {a % b, a / b};
      3'd6: p[63:32] = a;
      default: p[31:0] = a;
    endcase
    {model_hi, model_lo} = p;
  endtask
  // Drive a Start pulse; the model decides whether the unit is free to take it
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic dz;
    Op = op; A = a; B = b; Start = 1;
    if (cyc >= pend_done) begin
      model(op, a, b, dz);
      e.cyc = cyc + 1 + (op[2:1] == 2'b11 ? 0 : 32);
      e.hi = model_hi; e.lo = model_lo; e.dz = dz;
      q.push_back(e);
      pend_done = e.cyc;
      if (op[2:1] != 2'b11) begin
        run_from = cyc + 1;
        run_to = cyc + 33;
      end
    end
    step(1);
    Start = 0;
    A = $urandom; B = $urandom;
  endtask
  task automatic wait_fin();
    int guard = 0;
    while (cyc < pend_done && guard < 100) begin
      step(1);
      guard++;
    end
  endtask
  task automatic do_reset(input logic with_start);
    Reset = 1; Start = with_start; Op = 3'd0; A = $urandom; B = $urandom;
    step(1);
    Reset = 0; Start = 0;
    q.delete();
    model_hi = 0; model_lo = 0; arch_hi = 0; arch_lo = 0;
    pend_done = 0; run_from = 0; run_to = 0;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    step(2);
    do_reset(0);
    started = 1;
    step(1);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    step(3);
    issue(3'd1, 32'h5, 32'h7);
    wait_fin();
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_fin();
    step(1);
    issue(3'd7, 32'hFFFF_FFFF, 32'd0);
    wait_fin();
    issue(3'd2, 32'd1, 32'd1);
    wait_fin();
    issue(3'd3, 32'd1, 32'd1);
    wait_fin();
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    wait_fin();
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_fin();
    issue(3'd5, 32'd7, 32'd0);
    wait_fin();
    step(1);
    issue(3'd6, 32'h1234, 32'd0);
    step(2);
    issue(3'd0, $urandom, $urandom);
    step(8);
    do_reset(1);
    step(40);
    issue(3'd4, 32'd100, 32'd7);
    wait_fin();
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 4) == 0) begin
        step($urandom_range(0, 6));
        issue(3'($urandom_range(0, 7)), pick(), pick());
      end
      wait_fin();
      step($urandom_range(0, 2));
    end
    wait_fin();
    step(3);
    chk("drain", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
